// File: rtl/gate_sweep_pkg.sv
// ---------------------------------------------------------------
// gate_sweep_pkg : shared states and NOR truth table | rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;

  // Bit i is the expected NOR output for vector {a,b} = i.
  localparam logic [NUM_VECTORS-1:0] EXP_NOR = 4'b0001;

endpackage

`default_nettype wire

// File: rtl/gate_sweep_timer.sv
// ---------------------------------------------------------------
// gate_sweep_timer : per-vector hold counter | rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module gate_sweep_timer #(
  parameter int HOLD_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The sample cycle is the last of the hold, so drive ends one count early.
  assign tc = (cnt_q == 8'(HOLD_CYCLES - 2));

endmodule

`default_nettype wire

// File: rtl/gate_sweep.sv
// ---------------------------------------------------------------
// gate_sweep : truth-table sweep of an external 2-input NOR | rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module gate_sweep
  import gate_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] result_vec
);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] res_q, res_d;

  logic       tmr_clr;
  logic       tmr_en;
  logic       tmr_tc;

  gate_sweep_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(tmr_clr),
    .en (tmr_en),
    .tc (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    res_d   = res_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;

    case (state_q)
      IDLE, FINISH: begin
        // A new sweep also wipes the previous verdict held in FINISH.
        if (start) begin
          state_d = DRIVE;
          idx_d   = 2'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = 3'd0;
          res_d   = 4'd0;
          tmr_clr = 1'b1;
        end
      end

      DRIVE: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        res_d[idx_q] = c;
        if (c != EXP_NOR[idx_q]) begin
          err_d = err_q + 3'd1;
        end
        tmr_clr = 1'b1;
        if (idx_q == 2'(NUM_VECTORS - 1)) begin
          state_d = FINISH;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 3'd0);
        end else begin
          state_d    = DRIVE;
          idx_d      = idx_q + 2'd1;
          {a_d, b_d} = idx_q + 2'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      res_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign result_vec = res_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep.sv
// ---------------------------------------------------------------
// tb_gate_sweep : random sweeps on HOLD_CYCLES 5 and 2 | rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_gate_sweep;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       noise;
  logic [1:0] mode;   // 0 real NOR, 1 stuck-at-1, 2 stuck-at-0, 3 random c
  bit         chk_en = 1'b0;
  int         tests  = 0;
  int         fails  = 0;

  typedef struct {
    int res;
    int err;
    int pass;
    int cyc;
  } exp_t;

  always #5 clk = ~clk;

  // Rising edges sit at 10k+5, so this is the index of the current cycle.
  function automatic int now_cyc();
    return int'($time / 10);
  endfunction

  task automatic chk(input int h, input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL h%0d_%s: got %0d expected %0d (cycle %0d)", h, name, act, exp, now_cyc());
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam int H = (g == 0) ? 5 : 2;

    logic       a, b, c, busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] result_vec;

    assign c = (mode == 2'd0) ? ~(a | b) :
               (mode == 2'd1) ? 1'b1 :
               (mode == 2'd2) ? 1'b0 : noise;

    gate_sweep #(
      .HOLD_CYCLES(H)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .c         (c),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .result_vec(result_vec)
    );

    exp_t q[$];
    bit   m_busy = 1'b0;
    bit   m_done = 1'b0;
    int   m_t    = 0;
    int   m_err  = 0;
    int   m_res  = 0;
    int   m_acc  = 0;
    bit   prev_done = 1'b0;

    // Reference: sweep time m_t counts cycles since the accepted start;
    // vector k occupies m_t in [k*H, k*H+H-1] and c is taken at its last cycle.
    always @(posedge clk) begin
      int k, va, vb, expc;
      if (rst) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_err  = 0;
        m_res  = 0;
      end else if (m_busy) begin
        if (m_t % H == H - 1) begin
          k    = m_t / H;
          va   = k / 2;
          vb   = k % 2;
          expc = (va == 0 && vb == 0) ? 1 : 0;
          if (int'(c) != expc) m_err++;
          if (c) m_res = m_res | (1 << k);
        end
        if (m_t == 4 * H - 1) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          q.push_back('{m_res, m_err, (m_err == 0) ? 1 : 0, m_acc + 4 * H + 1});
        end else begin
          m_t++;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_done = 1'b0;
        m_t    = 0;
        m_err  = 0;
        m_res  = 0;
        m_acc  = now_cyc();
      end
    end

    always @(negedge clk) begin
      int   v;
      exp_t e;
      if (chk_en) begin
        v = m_busy ? m_t / H : 0;
        chk(H, "a", int'(a), v / 2);
        chk(H, "b", int'(b), v % 2);
        chk(H, "busy", int'(busy), int'(m_busy));
        chk(H, "done", int'(done), int'(m_done));
        if (!m_busy) begin
          chk(H, "err_count", int'(err_count), m_err);
          chk(H, "result_vec", int'(result_vec), m_res);
          chk(H, "pass", int'(pass), (m_done && m_err == 0) ? 1 : 0);
        end
        if (done && !prev_done) begin
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL h%0d_sb_done: got unexpected done expected none (cycle %0d)", H, now_cyc());
          end else begin
            e = q.pop_front();
            chk(H, "sb_result_vec", int'(result_vec), e.res);
            chk(H, "sb_err_count", int'(err_count), e.err);
            chk(H, "sb_pass", int'(pass), e.pass);
            chk(H, "sb_done_cycle", now_cyc(), e.cyc);
          end
        end
        prev_done = done;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    noise = 1'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
    noise = 1'b0;
    step();
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    run(2);

    // Directed: good NOR, stuck-at-1, stuck-at-0.
    for (int m = 0; m < 3; m++) begin
      mode = 2'(m);
      pulse_start();
      run(25);
    end

    // Reset while the H=5 instance drives vector 2, then a clean sweep.
    mode = 2'd0;
    pulse_start();
    run(11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(3);
    pulse_start();
    run(25);

    // start together with rst, then start pulses while busy.
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    run(3);
    pulse_start();
    run(3);
    pulse_start();
    run(6);
    pulse_start();
    run(25);

    // Random c behaviour, stray starts and occasional resets.
    for (int s = 0; s < 30; s++) begin
      mode = 2'($urandom_range(0, 3));
      pulse_start();
      for (int i = 0; i < 25; i++) begin
        start = ($urandom_range(0, 7) == 0);
        rst   = ($urandom_range(0, 63) == 0);
        step();
      end
      start = 1'b0;
      rst   = 1'b0;
    end
    run(30);

    // Any sweep the reference finished must have been seen from the DUT.
    chk(5, "sb_leftover", g_ch[0].q.size(), 0);
    chk(2, "sb_leftover", g_ch[1].q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gate_sweep.md
GATE_SWEEP -- requirements
Module: gate_sweep

Interface
REQ-001 Parameter HOLD_CYCLES, default 5: clock cycles each input vector is held; legal range 2..255.
REQ-002 Parameter sequence: clk, rst, start, a, b, c, busy, done, pass, err_count, result_vec.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a truth-table sweep.
REQ-006 a  output  1  first operand driven to the two-input NOR under test.
REQ-007 b  output  1  second operand driven to the NOR under test.
REQ-008 c  input  1  NOR output returned from the unit under test.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high from sweep completion until the next accepted start or rst.
REQ-011 pass  output  1  valid when done: 1 iff err_count == 0.
REQ-012 err_count  output  3  number of vectors whose sampled c differed from expected.
REQ-013 result_vec  output  4  sampled c per vector; bit i holds vector i, where i = {a,b}.

Function
REQ-014 FSM states: IDLE, DRIVE, SAMPLE, FINISH.
REQ-015 IDLE: a=b=0, busy=0; start=1 -> DRIVE with vector index 0, hold counter 0, err_count 0, result_vec 0, done 0.
REQ-016 Vector order: index 0..3 maps to {a,b} = 00, 01, 10, 11; a,b are registered from the index.
REQ-017 DRIVE: hold counter increments each cycle; at count HOLD_CYCLES-2 -> SAMPLE (total HOLD_CYCLES cycles per vector including SAMPLE).
REQ-018 SAMPLE: one cycle; captures c into result_vec[index]; if c != ~(a|b), err_count increments.
REQ-019 After SAMPLE: if index < 3 -> DRIVE with index+1 and counter 0; if index == 3 -> FINISH.
REQ-020 FINISH: a=b=0, busy=0, done=1; pass = (err_count == 0); outputs held until leaving FINISH.
REQ-021 Expected-value table: 00->1, 01->0, 10->0, 11->0.
REQ-022 Latency: start accepted in cycle N -> done rises in cycle N + 4*HOLD_CYCLES + 1.
REQ-023 start while busy (DRIVE/SAMPLE) is ignored; no restart, no counter change.
REQ-024 start in FINISH: accepted as a new sweep; done, pass, err_count, result_vec cleared in the same edge.
REQ-025 busy = 1 exactly in DRIVE and SAMPLE.
REQ-026 err_count never exceeds 4; no wrap logic needed, width is sufficient.
REQ-027 c is sampled only in SAMPLE; c values in all other cycles are ignored.

Reset
REQ-028 rst=1 at any edge, including mid-sweep: state IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, result_vec=0, index 0, hold counter 0.
REQ-029 rst has priority over start in the same cycle.

Structure
REQ-030 Package gate_sweep_pkg holds the FSM state enum, NUM_VECTORS=4 and the expected NOR table constant.
REQ-031 One sub-module, gate_sweep_timer: hold counter with clear, enable and terminal-count output, parameterized by HOLD_CYCLES.

Verification
REQ-032 Bench connects a behavioural NOR (c = ~(a|b)); start pulse with HOLD_CYCLES=5 -> done after 21 cycles, pass=1, err_count=0, result_vec=4'b0001.
REQ-033 Stuck-at-1 c -> err_count=3, pass=0, result_vec=4'b1111.
REQ-034 Stuck-at-0 c -> err_count=1, pass=0, result_vec=4'b0000.
REQ-035 rst asserted during vector 2 (a=1,b=0) -> next cycle all outputs 0, state IDLE; a later start completes a clean sweep.
REQ-036 start pulses during busy, and start together with rst -> ignored; done timing unchanged from the first accepted start.
REQ-037 a,b check: each vector held exactly HOLD_CYCLES cycles in order 00,01,10,11; a=b=0 in IDLE and FINISH; repeat with HOLD_CYCLES=2.
